fr_align: RTL

- Per-channel frame-alignment controller for the fast-ADC deserialisers.
- Compares each channel's deserialised frame word against the correct frame pattern 8'hf0.
- Issues single-cycle bitslip pulses to the ISERDES until the pattern is stable, then reports per-channel lock.
- Sits between the ISERDES frame outputs and the frame monitor; it produces the alignment that the monitor checks.

---
 rtl/fr_pkg.sv | 9 +
 rtl/fr_align_ch.sv | 100 ++++++++++
 rtl/fr_align.sv | 42 ++++
 3 files changed

// File: rtl/fr_pkg.sv
// fr_pkg: shared constants and channel state type for the frame aligner
package fr_pkg;
   localparam int FR_W = 8;
   localparam logic [FR_W-1:0] FR_COR = 8'hf0;
   typedef enum logic [2:0] {CHECK, SLIP, WAIT, LOCKED, FAIL} fr_state_t;
   function automatic int cw(input int v);
      return ($clog2(v + 1) < 1) ? 1 : $clog2(v + 1);
   endfunction
endpackage

// File: rtl/fr_align_ch.sv
// fr_align_ch: one channel's frame register, bitslip alignment FSM and counters
// FR_RELOCK_EN: a locked channel re-aligns after LOSS_CNT consecutive mismatches
module fr_align_ch
   import fr_pkg::*;
#(
   parameter int LOCK_CNT  = 16,
   parameter int SETTLE    = 8,
   parameter int MAX_SLIPS = 8,
   parameter int LOSS_CNT  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [FR_W-1:0] fr,
   input  logic            realign,
   output logic            bitslip,
   output logic            locked,
   output logic            fail
);
`ifdef FR_RELOCK_EN
   localparam bit RELOCK = 1'b1;
`else
   localparam bit RELOCK = 1'b0;
`endif
   localparam int MW = cw(LOCK_CNT);
   localparam int SW = cw(MAX_SLIPS);
   localparam int WW = cw(SETTLE);
   localparam int LW = cw(LOSS_CNT);
   localparam logic [MW-1:0] M_LAST = MW'(LOCK_CNT - 1);
   localparam logic [SW-1:0] S_MAX  = SW'(MAX_SLIPS);
   localparam logic [WW-1:0] W_INIT = WW'(SETTLE - 1);
   localparam logic [LW-1:0] L_LAST = LW'(LOSS_CNT - 1);
   fr_state_t       state, state_nx;
   logic [FR_W-1:0] fr_q;
   logic [MW-1:0]   match_cnt, match_nx;
   logic [SW-1:0]   slip_cnt, slip_nx;
   logic [WW-1:0]   wait_cnt, wait_nx;
   logic [LW-1:0]   loss_cnt, loss_nx;
   logic            match, lost, clr;
   logic            bitslip_d, locked_d, fail_d;
   assign match = fr_q == FR_COR;
   assign clr   = !rst_n || realign;
   // loss tracking only takes effect when relock is built in
   assign lost    = RELOCK && state == LOCKED && !match && loss_cnt == L_LAST;
   assign loss_nx = (state != LOCKED || match || lost) ? '0 : loss_cnt + 1'b1;

   always_ff @(posedge clk) begin
      fr_q <= fr;
      if (clr) begin
         state     <= CHECK;
         match_cnt <= '0;
         slip_cnt  <= '0;
         wait_cnt  <= '0;
         loss_cnt  <= '0;
      end else begin
         state     <= state_nx;
         match_cnt <= match_nx;
         slip_cnt  <= slip_nx;
         wait_cnt  <= wait_nx;
         loss_cnt  <= loss_nx;
      end
      bitslip <= rst_n && bitslip_d;
      locked  <= rst_n && locked_d;
      fail    <= rst_n && fail_d;
   end

   always_comb begin
      state_nx = state;
      match_nx = match_cnt;
      slip_nx  = slip_cnt;
      wait_nx  = wait_cnt;
      case (state)
         CHECK: begin
            match_nx = match ? match_cnt + 1'b1 : '0;
            state_nx = match ? ((match_cnt == M_LAST) ? LOCKED : CHECK)
                             : ((slip_cnt == S_MAX) ? FAIL : SLIP);
         end
         SLIP: begin
            slip_nx  = (slip_cnt == S_MAX) ? slip_cnt : slip_cnt + 1'b1;
            wait_nx  = W_INIT;
            state_nx = WAIT;
         end
         WAIT: begin
            wait_nx  = (wait_cnt == '0) ? '0 : wait_cnt - 1'b1;
            state_nx = (wait_cnt == '0) ? CHECK : WAIT;
         end
         LOCKED: begin
            state_nx = lost ? CHECK : LOCKED;
            match_nx = lost ? '0 : match_cnt;
            slip_nx  = lost ? '0 : slip_cnt;
         end
         default: ;
      endcase
   end

   always_comb begin
      bitslip_d = state == SLIP;
      locked_d  = state == LOCKED;
      fail_d    = state == FAIL;
   end
endmodule

// File: rtl/fr_align.sv
// fr_align: N_CH independent frame-alignment channels plus a registered all_locked
// FR_RELOCK_EN: passed through to each channel to allow lock loss and re-alignment
module fr_align
   import fr_pkg::*;
#(
   parameter int N_CH      = 5,
   parameter int LOCK_CNT  = 16,
   parameter int SETTLE    = 8,
   parameter int MAX_SLIPS = 8,
   parameter int LOSS_CNT  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [FR_W*N_CH-1:0] fr,
   input  logic                 realign,
   output logic [N_CH-1:0]      bitslip,
   output logic [N_CH-1:0]      locked,
   output logic [N_CH-1:0]      fail,
   output logic                 all_locked
);
   genvar k;
   generate
      for (k = 0; k < N_CH; k++) begin : g_ch
         fr_align_ch #(
            .LOCK_CNT (LOCK_CNT),
            .SETTLE   (SETTLE),
            .MAX_SLIPS(MAX_SLIPS),
            .LOSS_CNT (LOSS_CNT)
         ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .fr     (fr[FR_W*k +: FR_W]),
            .realign(realign),
            .bitslip(bitslip[k]),
            .locked (locked[k]),
            .fail   (fail[k])
         );
      end
   endgenerate

   always_ff @(posedge clk) all_locked <= rst_n && &locked;
endmodule
